// File: rtl/latch_bank_ctrl.sv
// -----------------------------------------------------------------------------
// latch_bank_ctrl
//
// Write controller and round-robin arbiter for a small bank of level-sensitive
// D-latches. Each write is a fixed three-phase sequence:
//   SETUP : data driven on o_lat_d, all gates closed
//   OPEN  : gate of the addressed word open, data unchanged
//   HOLD  : gate closed again, data still held, o_done pulsed
// Data is therefore stable for a full cycle on both sides of the transparent
// window. All latch-facing and handshake outputs come straight from flops.
//
// Ports
//   i_clk       : clock, all state changes on the rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_req       : [N_REQ]     level write request per requester
//   i_req_addr  : [N_REQ*AW]  flattened word addresses, requester i at [i*AW +: AW]
//   i_req_data  : [N_REQ*DW]  flattened write data, requester i at [i*DW +: DW]
//   o_gnt       : [N_REQ]     one-hot 1-cycle grant pulse
//   o_done      : [N_REQ]     one-hot 1-cycle completion pulse
//   o_busy      : high whenever the controller is not idle
//   o_lat_d     : [DW]        D bus to all latch words
//   o_lat_en    : [DEPTH]     per-word gate enable, at most one bit high
// -----------------------------------------------------------------------------
module latch_bank_ctrl #(
    parameter int N_REQ = 2,
    parameter int DW    = 8,
    parameter int AW    = 2,
    localparam int DEPTH = 2 ** AW
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ*AW-1:0]   i_req_addr,
    input  logic [N_REQ*DW-1:0]   i_req_data,
    output logic [N_REQ-1:0]      o_gnt,
    output logic [N_REQ-1:0]      o_done,
    output logic                  o_busy,
    output logic [DW-1:0]         o_lat_d,
    output logic [DEPTH-1:0]      o_lat_en
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_OPEN  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Round-robin search upward from ptr with wrap-around.
    // Returns {found, index}; the lowest offset from ptr wins.
    function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] reqs,
                                            input logic [PW-1:0]    ptr);
        logic [PW:0]      res;
        logic [N_REQ-1:0] shifted;
        int               idx;
        res = {(PW+1){1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx     = (int'(ptr) + k) % N_REQ;
            shifted = reqs >> idx;
            if (shifted[0]) begin
                res = {1'b1, PW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // One-hot vector selecting requester idx.
    function automatic logic [N_REQ-1:0] req_onehot(input logic [PW-1:0] idx);
        logic [N_REQ-1:0] one;
        one = {{(N_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // One-hot gate vector for word addr.
    function automatic logic [DEPTH-1:0] addr_onehot(input logic [AW-1:0] addr);
        logic [DEPTH-1:0] one;
        one = {{(DEPTH-1){1'b0}}, 1'b1};
        return one << addr;
    endfunction

    // Next round-robin pointer after granting idx.
    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
        logic [PW-1:0] nxt;
        if (int'(idx) == N_REQ - 1) begin
            nxt = {PW{1'b0}};
        end else begin
            nxt = idx + {{(PW-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    state_t             r_state;
    logic [PW-1:0]      r_rr_ptr;
    logic [PW-1:0]      r_cur;       // requester whose write is in flight
    logic               r_b2b;       // a back-to-back grant was issued into HOLD
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_data;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_done;
    logic               r_busy;
    logic [DW-1:0]      r_lat_d;
    logic [DEPTH-1:0]   r_lat_en;

    logic [PW:0]        w_pick;
    logic               w_found;
    logic [PW-1:0]      w_idx;
    logic [AW-1:0]      w_win_addr;
    logic [DW-1:0]      w_win_data;
    logic [N_REQ-1:0]   w_cand;

    // Candidate requests: in IDLE everyone, otherwise exclude the requester being served.
    always_comb begin
        w_cand = i_req;
        if (r_state == ST_IDLE) begin
            w_cand = i_req;
        end else begin
            w_cand = i_req & ~req_onehot(r_cur);
        end
    end

    assign w_pick     = rr_pick(w_cand, r_rr_ptr);
    assign w_found    = w_pick[PW];
    assign w_idx      = w_pick[PW-1:0];
    assign w_win_addr = i_req_addr[int'(w_idx)*AW +: AW];
    assign w_win_data = i_req_data[int'(w_idx)*DW +: DW];

    // Write sequencer: arbitration, capture and all registered outputs.
    //
    // The back-to-back arbitration is evaluated on the OPEN->HOLD edge so that
    // the next grant is visible during HOLD alongside done of the current write;
    // this keeps the sustained rate at one write every three cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= {PW{1'b0}};
            r_cur    <= {PW{1'b0}};
            r_b2b    <= 1'b0;
            r_addr   <= {AW{1'b0}};
            r_data   <= {DW{1'b0}};
            r_gnt    <= {N_REQ{1'b0}};
            r_done   <= {N_REQ{1'b0}};
            r_busy   <= 1'b0;
            r_lat_d  <= {DW{1'b0}};
            r_lat_en <= {DEPTH{1'b0}};
        end else begin
            r_gnt  <= {N_REQ{1'b0}};
            r_done <= {N_REQ{1'b0}};
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= req_onehot(w_idx);
                        r_cur    <= w_idx;
                        r_rr_ptr <= ptr_after(w_idx);
                        r_addr   <= w_win_addr;
                        r_data   <= w_win_data;
                        r_lat_d  <= w_win_data;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SETUP;
                    end else begin
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    r_lat_en <= addr_onehot(r_addr);
                    r_state  <= ST_OPEN;
                end
                ST_OPEN: begin
                    r_lat_en <= {DEPTH{1'b0}};
                    r_done   <= req_onehot(r_cur);
                    r_state  <= ST_HOLD;
                    if (w_found) begin
                        r_gnt    <= req_onehot(w_idx);
                        r_cur    <= w_idx;
                        r_rr_ptr <= ptr_after(w_idx);
                        r_addr   <= w_win_addr;
                        r_data   <= w_win_data;
                        r_b2b    <= 1'b1;
                    end else begin
                        r_b2b    <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    r_b2b <= 1'b0;
                    if (r_b2b) begin
                        // Data bus moves only now, a full cycle after the gate closed.
                        r_lat_d <= r_data;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETUP;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_lat_en <= {DEPTH{1'b0}};
                    r_b2b    <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt    = r_gnt;
    assign o_done   = r_done;
    assign o_busy   = r_busy;
    assign o_lat_d  = r_lat_d;
    assign o_lat_en = r_lat_en;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_latch_bank_ctrl
//
// Directed self-checking bench for latch_bank_ctrl (N_REQ=2, DW=8, AW=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they reflect the state of the cycle just entered.
// -----------------------------------------------------------------------------
module tb_latch_bank_ctrl;

    localparam int N_REQ = 2;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic                i_clk;
    logic                i_rst_n;
    logic [N_REQ-1:0]    i_req;
    logic [N_REQ*AW-1:0] i_req_addr;
    logic [N_REQ*DW-1:0] i_req_data;
    logic [N_REQ-1:0]    o_gnt;
    logic [N_REQ-1:0]    o_done;
    logic                o_busy;
    logic [DW-1:0]       o_lat_d;
    logic [DEPTH-1:0]    o_lat_en;

    int n_checks = 0;
    int n_errors = 0;

    latch_bank_ctrl #(.N_REQ(N_REQ), .DW(DW), .AW(AW)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_req_addr (i_req_addr),
        .i_req_data (i_req_data),
        .o_gnt      (o_gnt),
        .o_done     (o_done),
        .o_busy     (o_busy),
        .o_lat_d    (o_lat_d),
        .o_lat_en   (o_lat_en)
    );

    // Free-running clock, period 10.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_req   = 2'b00;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check_val(tag, 32'(o_busy), 32'd0);
    endtask

    logic [DW-1:0]    prev_d;
    logic [DEPTH-1:0] prev_en;
    logic [N_REQ-1:0] gnt_seq [6];
    int               gnt_cyc [6];
    int               n_gnt;
    int               n_en;

    initial begin
        i_rst_n    = 1'b1;
        i_req      = 2'b00;
        i_req_addr = '0;
        i_req_data = '0;
        #2;
        do_reset();

        // Reset state
        check_val("rst_gnt",  32'(o_gnt),    32'd0);
        check_val("rst_done", 32'(o_done),   32'd0);
        check_val("rst_busy", 32'(o_busy),   32'd0);
        check_val("rst_latd", 32'(o_lat_d),  32'd0);
        check_val("rst_laten",32'(o_lat_en), 32'd0);

        // ---------------- Single write: addr 2, data 0xA5 ----------------
        i_req_addr = {2'd0, 2'd2};
        i_req_data = {8'h00, 8'hA5};
        i_req      = 2'b01;                       // cycle 0
        tick();                                   // cycle 1
        check_val("s_c1_gnt",   32'(o_gnt),    32'h1);
        check_val("s_c1_latd",  32'(o_lat_d),  32'hA5);
        check_val("s_c1_laten", 32'(o_lat_en), 32'h0);
        check_val("s_c1_busy",  32'(o_busy),   32'h1);
        tick();                                   // cycle 2
        check_val("s_c2_laten", 32'(o_lat_en), 32'h4);
        check_val("s_c2_gnt",   32'(o_gnt),    32'h0);
        check_val("s_c2_done",  32'(o_done),   32'h0);
        tick();                                   // cycle 3
        check_val("s_c3_done",  32'(o_done),   32'h1);
        check_val("s_c3_laten", 32'(o_lat_en), 32'h0);
        check_val("s_c3_latd",  32'(o_lat_d),  32'hA5);
        i_req = 2'b00;
        tick();                                   // cycle 4
        check_val("s_c4_busy",  32'(o_busy),   32'h0);
        check_val("s_c4_done",  32'(o_done),   32'h0);
        check_val("s_c4_latd",  32'(o_lat_d),  32'hA5);

        // ---------------- Simultaneous requests ----------------
        do_reset();
        i_req_addr = {2'd1, 2'd0};
        i_req_data = {8'h22, 8'h11};
        i_req      = 2'b11;                       // cycle 0
        tick();                                   // cycle 1
        check_val("m_c1_gnt",   32'(o_gnt),    32'h1);
        check_val("m_c1_latd",  32'(o_lat_d),  32'h11);
        tick();                                   // cycle 2
        check_val("m_c2_laten", 32'(o_lat_en), 32'h1);
        tick();                                   // cycle 3
        check_val("m_c3_done",  32'(o_done),   32'h1);
        check_val("m_c3_gnt",   32'(o_gnt),    32'h2);
        check_val("m_c3_latd",  32'(o_lat_d),  32'h11);
        i_req = 2'b10;
        tick();                                   // cycle 4
        check_val("m_c4_latd",  32'(o_lat_d),  32'h22);
        check_val("m_c4_laten", 32'(o_lat_en), 32'h0);
        check_val("m_c4_busy",  32'(o_busy),   32'h1);
        tick();                                   // cycle 5
        check_val("m_c5_laten", 32'(o_lat_en), 32'h2);
        tick();                                   // cycle 6
        check_val("m_c6_done",  32'(o_done),   32'h2);
        check_val("m_c6_gnt",   32'(o_gnt),    32'h0);
        i_req = 2'b00;
        tick();                                   // cycle 7
        check_val("m_c7_busy",  32'(o_busy),   32'h0);

        // ---------------- Fairness: both requesters continuously ----------------
        do_reset();
        i_req_addr = {2'd3, 2'd2};
        i_req_data = {8'h5C, 8'hC3};
        i_req      = 2'b11;                       // cycle 0
        n_gnt      = 0;
        prev_d     = o_lat_d;
        prev_en    = o_lat_en;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            tick();
            check_val("f_onehot0", 32'($onehot0(o_lat_en)), 32'd1);
            if (o_lat_en != 4'b0000 || prev_en != 4'b0000) begin
                check_val("f_d_stable", 32'(o_lat_d), 32'(prev_d));
            end else begin
                prev_d = prev_d;
            end
            if (o_gnt != 2'b00 && n_gnt < 6) begin
                gnt_seq[n_gnt] = o_gnt;
                gnt_cyc[n_gnt] = cyc;
                n_gnt++;
                if (n_gnt == 6) i_req = 2'b00;
            end
            prev_d  = o_lat_d;
            prev_en = o_lat_en;
        end
        check_val("f_n_gnt", 32'(n_gnt), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < n_gnt) begin
                check_val("f_gnt_order", 32'(gnt_seq[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
            end
        end
        if (n_gnt == 6) check_val("f_gnt6_cycle", 32'(gnt_cyc[5]), 32'd15);
        wait_idle("f_idle");

        // ---------------- Reset in the middle of OPEN ----------------
        i_req_addr = {2'd0, 2'd3};
        i_req_data = {8'h00, 8'h5A};
        i_req      = 2'b01;                       // cycle 0
        tick();                                   // cycle 1
        tick();                                   // cycle 2, OPEN
        check_val("r_c2_laten", 32'(o_lat_en), 32'h8);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_val("r_async_laten", 32'(o_lat_en), 32'h0);
        check_val("r_async_latd",  32'(o_lat_d),  32'h0);
        check_val("r_async_busy",  32'(o_busy),   32'h0);
        i_req = 2'b00;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("r_no_done", 32'(o_done), 32'h0);
        end
        check_val("r_busy_after", 32'(o_busy), 32'h0);
        // Pointer back at 0: requester 0 wins a tie.
        i_req_addr = {2'd1, 2'd0};
        i_req_data = {8'h77, 8'h66};
        i_req      = 2'b11;
        tick();
        check_val("r_ptr_zero", 32'(o_gnt), 32'h1);
        i_req = 2'b00;
        wait_idle("r_idle");

        // ---------------- Re-request one cycle past done ----------------
        do_reset();
        i_req_addr = {2'd0, 2'd1};
        i_req_data = {8'h00, 8'h33};
        i_req      = 2'b01;                       // cycle 0
        tick();                                   // cycle 1
        check_val("q_c1_gnt",  32'(o_gnt),  32'h1);
        tick();                                   // cycle 2
        tick();                                   // cycle 3
        check_val("q_c3_done", 32'(o_done), 32'h1);
        tick();                                   // cycle 4, req still high
        check_val("q_c4_busy", 32'(o_busy), 32'h0);
        check_val("q_c4_gnt",  32'(o_gnt),  32'h0);
        tick();                                   // cycle 5
        check_val("q_c5_gnt",  32'(o_gnt),  32'h1);
        i_req = 2'b00;
        tick();                                   // cycle 6
        check_val("q_c6_laten",32'(o_lat_en), 32'h2);
        tick();                                   // cycle 7
        check_val("q_c7_done", 32'(o_done), 32'h1);
        wait_idle("q_idle");

        // ---------------- Address sweep ----------------
        for (int a = 0; a < 4; a++) begin
            i_req_addr = {2'd0, 2'(a)};
            i_req_data = {8'h00, 8'(8'h10 + a)};
            i_req      = 2'b01;                   // cycle 0
            n_en       = 0;
            for (int c = 1; c <= 4; c++) begin
                tick();
                if (o_lat_en != 4'b0000) n_en++;
                if (c == 2) begin
                    check_val("a_laten", 32'(o_lat_en), 32'(4'b0001 << a));
                    check_val("a_latd",  32'(o_lat_d),  32'(8'h10 + a));
                end else if (c == 3) begin
                    i_req = 2'b00;
                end else begin
                    n_en = n_en;
                end
            end
            check_val("a_once", 32'(n_en), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/latch_bank_ctrl.md
# latch_bank_ctrl

Write controller and arbiter for a small bank of level-sensitive D-latches used as storage. It shares the bank between `N_REQ` requesters using round-robin arbitration. Each write runs as a fixed three-phase sequence: data setup with gate closed, gate open, gate closed with data held. This keeps every latch's D stable across its whole transparent window and across the closing edge, so setup and hold are met by construction. The block sits between the requesters and the latch array and is the only driver of the latch D bus and the gate enables.

## Interface
- `N_REQ`, 2 — number of requesters (2..8)
- `DW`, 8 — data width of each latch word
- `AW`, 2 — address width; bank depth is `DEPTH = 2**AW`
- `clk` in 1 — single clock; all state changes on its rising edge
- `rst_n` in 1 — reset, asynchronous and active-low
- `req` in `N_REQ` — level write request, one bit per requester
- `req_addr` in `N_REQ*AW` — flattened word addresses; requester i uses bits [i*AW +: AW]
- `req_data` in `N_REQ*DW` — flattened write data; requester i uses bits [i*DW +: DW]
- `gnt` out `N_REQ` — one-hot, 1-cycle pulse; the requester's address and data are captured on this cycle
- `done` out `N_REQ` — one-hot, 1-cycle pulse; the write has completed and the latch has closed
- `busy` out 1 — high whenever the state is not IDLE
- `lat_d` out `DW` — D bus to all latch words
- `lat_en` out `DEPTH` — per-word gate, at most one bit high at a time

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD.
- **IDLE**
  - If any `req` bit is high, pick a winner by round-robin, starting from pointer `rr_ptr`.
  - Capture the winner's addr and data into internal registers, register `gnt[winner]`, and go to SETUP.
  - Otherwise stay in IDLE.
- **SETUP**
  - `lat_d` = captured data, `lat_en` = 0.
  - Go to OPEN.
- **OPEN**
  - `lat_en[captured_addr]` = 1, `lat_d` unchanged.
  - Go to HOLD.
- **HOLD**
  - `lat_en` = 0, `lat_d` unchanged, `done[winner]` = 1.
  - Arbitrate among pending `req` bits, excluding the requester currently being served.
  - If a winner exists: capture its addr/data, pulse `gnt`, and go to SETUP. This is the back-to-back path.
  - Otherwise go to IDLE.
- **Round-robin pointer**: after granting requester i, `rr_ptr` = (i+1) mod `N_REQ`. Search is upward from `rr_ptr` with wrap-around.
- **Requester protocol**
  - Hold `req` high until `done`, then drop it the following cycle.
  - `req_addr` and `req_data` need only be valid during the `gnt` cycle.
  - A `req` still high in the cycle after `done` counts as a new write.
- **Output glitch freedom**: `lat_en`, `lat_d`, `gnt` and `done` come directly from flops, with no combinational decode after the flop.
- **Idle bus**: `lat_d` keeps its last driven value in IDLE and never changes while any `lat_en` bit is high.
- **Reset**: when `rst_n` = 0, immediately and regardless of clock:
  - state = IDLE, `rr_ptr` = 0
  - `lat_en` = 0, `lat_d` = 0, `gnt` = 0, `done` = 0, `busy` = 0
- **Reset mid-write**: the latch gate closes immediately and the write is abandoned. No `done` is issued, and the requester must re-request after reset.

## Timing
- Cycle numbering is relative to the cycle in which `req` is first sampled high in IDLE (cycle 0).
- From IDLE:
  - cycle 1: SETUP, `gnt` high
  - cycle 2: OPEN, `lat_en` high
  - cycle 3: HOLD, `done` high
  - cycle 4: IDLE, or SETUP for the next write
- Latency from `req` to `done` is 3 cycles. Sustained throughput is one write per 3 cycles when requests are back-to-back.
- `lat_d` is stable for at least one full cycle before `lat_en` rises and one full cycle after it falls.
- `gnt` and `done` are never high for the same requester in the same cycle. In HOLD with a back-to-back grant, `done[i]` and `gnt[j]` with j≠i are both high.
- Simultaneous requests while busy are queued implicitly by the `req` level and served in round-robin order.

## Test plan
- **Single write**: reset, then `req[0]`=1 with addr=2, data=0xA5.
  - Required: `gnt[0]` in cycle 1, `lat_d`=0xA5 from cycle 1, `lat_en`=4'b0100 in cycle 2 only, `done[0]` in cycle 3, IDLE in cycle 4.
- **Simultaneous requests**: `req`=2'b11 in IDLE after reset, addr0=0/data0=0x11, addr1=1/data1=0x22.
  - Required: requester 0 is served first and `done[0]` in cycle 3.
  - Requester 1 is granted in that same HOLD cycle (cycle 3), with `lat_en`=4'b0010 in cycle 5 and `done[1]` in cycle 6.
- **Fairness**: both requesters hold `req` high continuously for 6 writes.
  - Required: grants alternate 0,1,0,1,0,1; `lat_en` is never multi-hot; `lat_d` never changes while `lat_en`≠0.
- **Reset mid-write**: assert `rst_n`=0 asynchronously in the middle of OPEN.
  - Required: `lat_en`=0 and `lat_d`=0 immediately, without waiting for a clock edge; no `done`; after release, `busy`=0 and `rr_ptr`=0.
- **Re-request**: requester 0 keeps `req` high one cycle past `done[0]`.
  - Required: a second write by requester 0 starts from IDLE, with `gnt[0]` in cycle 5.
- **Address sweep**: write data 0x10+a to each address a=0..3.
  - Required: each `lat_en` bit fires exactly once, in address order.
